alu_share_arb: RTL and testbench
================================

# alu_share_arb

Arbiter and sequencer that shares the single datapath ALU between two requesters, e.g. the main pipeline's EX stage and a secondary multi-cycle unit. Each requester issues an operation (op code, A, B) over a valid/ready handshake. The block grants one requester at a time, drives the latched operands into one internal ALU instance, registers the result, and returns it on that requester's response channel. Arbitration is round-robin by default, or fixed-priority by parameter.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin between requesters; 1 = requester 0 always wins simultaneous requests.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req0_op` input 4: ALU op code.
- `req0_a` input 32: operand A.
- `req0_b` input 32: operand B.
- `rsp0_valid` output 1: result available for requester 0.
- `rsp0_ready` input 1: requester 0 takes the result.
- `rsp0_res` output 32: result.
- `rsp0_err` output 1: the op code was unsupported.
- `req1_*`, `rsp1_*`: identical set for requester 1.
- `busy` output 1: state is not IDLE.

## Operation
- Supported op codes match the datapath ALU:
  - 0000 add, 0010 sub, 0100 and, 0101 or, 0110 xor, 0111 nor, 1010 slt.
  - Any other code is unsupported. For those, the block produces res=0 and err=1, and its own decode never presents them to the ALU, so no stale value is used.
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If neither valid is high, stay.
  - If exactly one valid is high, grant it.
  - If both are high, grant by the priority pointer (round-robin) or grant requester 0 (FIXED_PRIO=1).
  - In the grant cycle, assert the grantee's `req_ready` for exactly that cycle.
  - Latch op, A, B and the grantee id. Go to EXEC.
  - `req_ready` is combinational: state==IDLE and grant to that requester. It never depends on `rsp_ready`.
- EXEC:
  - The ALU sees the latched op/A/B.
  - Capture the result (or 0 with err=1) into the result register. Go to RESP.
- RESP:
  - Assert `rspN_valid` for the latched grantee only. Hold `res` and `err` stable while valid is high.
  - On `rspN_valid && rspN_ready`, go to IDLE.
  - In round-robin mode, also set the priority pointer to the other requester.
- Only one transaction is in flight. No request is accepted in EXEC or RESP, so `req_ready` is 0 in both requesters during those states.
- Requesters must hold valid/op/A/B stable until ready is seen. The block does not check this.
- The non-granted requester's `rsp_valid` is always 0.
- Arithmetic: 32-bit. Add and sub wrap modulo 2^32 with no overflow flag.

## Timing
- Reset (synchronous, on a clk edge with reset=1):
  - state=IDLE, priority pointer=requester 0.
  - All `req_ready`, `rsp_valid`, `rsp_err` = 0.
  - `rsp_res` = 0, `busy` = 0.
- Latency: handshake in cycle N puts `rsp_valid` high in cycle N+2.
- Throughput, with `rsp_ready` tied high:
  - Response handshake in cycle N+2, IDLE in N+3, next accept in N+3.
  - That is one operation per 3 cycles.
- Back-pressure: `rsp_valid` stays high for any number of cycles until ready. The other requester waits; it is not starved beyond the current transaction.
- Simultaneous events:
  - A requester dropping valid in the same cycle the block grants it has no effect; the grant is evaluated on current inputs.
  - A new request arriving during RESP is granted in the first IDLE cycle.
- Reset mid-operation, in EXEC or RESP: the transaction is discarded and no response is issued. The pointer returns to requester 0.
- `busy` is 1 in EXEC and RESP, 0 in IDLE.

## Test plan
- Single requester, add: req0 op=0000, A=5, B=3, `rsp0_ready`=1.
  - Required: ready at N; `rsp0_valid` at N+2 with res=8, err=0.
  - Required: `rsp1_valid` stays 0 throughout.
- Sub wrap: req1 op=0010, A=0, B=1.
  - Required: res=0xFFFFFFFF, err=0, on `rsp1_valid` 2 cycles after accept.
- Round-robin contention: both requesters valid continuously (req0 add 1+1, req1 xor 0xF0^0xFF), FIXED_PRIO=0.
  - Required grant order: req0, req1, req0, …
  - Required results: 2 and 0x0F respectively, one grant every 3 cycles.
  - Repeat with FIXED_PRIO=1: req1 is granted only when req0 valid is low.
- Back-pressure: req0 and 0xFF00&0x0FF0 with `rsp0_ready` low for 5 cycles while req1 is valid.
  - Required: `rsp0_valid` high with res=0x0F00 for all 5 cycles; `req1_ready`=0 throughout.
  - Required: req1 is granted in the first IDLE cycle after the `rsp0` handshake.
- Unsupported op: req0 op=1111.
  - Required: res=0, err=1.
  - Required: the next valid op (or 7|8) returns res=15, err=0.
- Reset mid-op: assert reset in the RESP cycle.
  - Required: next cycle all outputs at reset values and no response ever issued.
  - Required: a fresh req1 then completes normally.

Source files
------------

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester arbiter/sequencer sharing one 32-bit ALU
//
// alu_share_alu : combinational 32-bit ALU (add, sub, and, or, xor, nor, slt)
//    op_i, a_i, b_i -> res_o
//
// alu_share_arb : grants one requester at a time, runs its op through the
// shared ALU and returns the registered result on that requester's channel.
//    FIXED_PRIO        0 = round-robin, 1 = requester 0 wins ties
//    clk, reset        rising-edge clock, synchronous active-high reset
//    reqN_valid/ready  operation handshake (ready is combinational)
//    reqN_op/a/b       op code and operands
//    rspN_valid/ready  result handshake
//    rspN_res/err      result, unsupported-op flag
//    busy              high while a transaction is in flight

module alu_share_alu (
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] res_o
);
   always_comb begin
      res_o = 32'd0;
      case (op_i)
         4'b0000: res_o = a_i + b_i;
         4'b0010: res_o = a_i - b_i;
         4'b0100: res_o = a_i & b_i;
         4'b0101: res_o = a_i | b_i;
         4'b0110: res_o = a_i ^ b_i;
         4'b0111: res_o = ~(a_i | b_i);
         4'b1010: res_o = {31'd0, $signed(a_i) < $signed(b_i)};
         default: res_o = 32'd0;
      endcase
   end
endmodule

module alu_share_arb #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_res,
   output logic        rsp0_err,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_res,
   output logic        rsp1_err,
   output logic        busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic        ptr_q;
   logic        gnt_id_q;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] res_q;
   logic        err_q;
   logic        rsp0_valid_q;
   logic        rsp1_valid_q;

   logic        gnt_sel;
   logic        gnt0;
   logic        gnt1;
   logic        op_ok;
   logic [3:0]  alu_op;
   logic [31:0] alu_res;

   // gnt_sel picks requester 1 when it is the only one asking, or when both
   // ask and the tie-break (pointer or fixed priority) favours it.
   always_comb begin
      gnt_sel = req1_valid;
      if (req0_valid && req1_valid) begin
         gnt_sel = (FIXED_PRIO != 0) ? 1'b0 : ptr_q;
      end
      gnt0 = (state_q == IDLE) && req0_valid && !gnt_sel;
      gnt1 = (state_q == IDLE) && req1_valid && gnt_sel;
   end

   // Unsupported codes are steered to a harmless add and the result is
   // forced to zero, so nothing undefined ever reaches the result register.
   always_comb begin
      case (op_q)
         4'b0000, 4'b0010, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1010: op_ok = 1'b1;
         default:                   op_ok = 1'b0;
      endcase
      alu_op = op_ok ? op_q : 4'b0000;
   end

   alu_share_alu u_alu (
      .op_i  (alu_op),
      .a_i   (a_q),
      .b_i   (b_q),
      .res_o (alu_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         gnt_id_q     <= 1'b0;
         op_q         <= 4'd0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         res_q        <= 32'd0;
         err_q        <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  gnt_id_q <= gnt1;
                  op_q     <= gnt1 ? req1_op : req0_op;
                  a_q      <= gnt1 ? req1_a  : req0_a;
                  b_q      <= gnt1 ? req1_b  : req0_b;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               res_q        <= op_ok ? alu_res : 32'd0;
               err_q        <= !op_ok;
               rsp0_valid_q <= !gnt_id_q;
               rsp1_valid_q <= gnt_id_q;
               state_q      <= RESP;
            end
            RESP: begin
               if ((rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready)) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  state_q      <= IDLE;
                  // Hand the next tie to whoever was not just served.
                  if (FIXED_PRIO == 0) begin
                     ptr_q <= !gnt_id_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_res   = res_q;
   assign rsp1_res   = res_q;
   assign rsp0_err   = err_q;
   assign rsp1_err   = err_q;
   assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb (round-robin and fixed-priority instances)

module tb_alu_share_arb;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        r0v [2];
   logic        r1v [2];
   logic        s0r [2];
   logic        s1r [2];
   logic [3:0]  r0op [2];
   logic [3:0]  r1op [2];
   logic [31:0] r0a [2];
   logic [31:0] r0b [2];
   logic [31:0] r1a [2];
   logic [31:0] r1b [2];
   logic        r0rdy [2];
   logic        r1rdy [2];
   logic        s0v [2];
   logic        s1v [2];
   logic        s0e [2];
   logic        s1e [2];
   logic        bsy [2];
   logic [31:0] s0res [2];
   logic [31:0] s1res [2];

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_share_arb #(.FIXED_PRIO(0)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(r0v[0]), .req0_ready(r0rdy[0]), .req0_op(r0op[0]), .req0_a(r0a[0]), .req0_b(r0b[0]),
      .rsp0_valid(s0v[0]), .rsp0_ready(s0r[0]), .rsp0_res(s0res[0]), .rsp0_err(s0e[0]),
      .req1_valid(r1v[0]), .req1_ready(r1rdy[0]), .req1_op(r1op[0]), .req1_a(r1a[0]), .req1_b(r1b[0]),
      .rsp1_valid(s1v[0]), .rsp1_ready(s1r[0]), .rsp1_res(s1res[0]), .rsp1_err(s1e[0]),
      .busy(bsy[0])
   );

   alu_share_arb #(.FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset),
      .req0_valid(r0v[1]), .req0_ready(r0rdy[1]), .req0_op(r0op[1]), .req0_a(r0a[1]), .req0_b(r0b[1]),
      .rsp0_valid(s0v[1]), .rsp0_ready(s0r[1]), .rsp0_res(s0res[1]), .rsp0_err(s0e[1]),
      .req1_valid(r1v[1]), .req1_ready(r1rdy[1]), .req1_op(r1op[1]), .req1_a(r1a[1]), .req1_b(r1b[1]),
      .rsp1_valid(s1v[1]), .rsp1_ready(s1r[1]), .rsp1_res(s1res[1]), .rsp1_err(s1e[1]),
      .busy(bsy[1])
   );

   typedef struct {
      int          r;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic logic rdy(input int d, input int r);
      return (r == 0) ? r0rdy[d] : r1rdy[d];
   endfunction
   function automatic logic rv(input int d, input int r);
      return (r == 0) ? s0v[d] : s1v[d];
   endfunction
   function automatic logic [31:0] rres(input int d, input int r);
      return (r == 0) ? s0res[d] : s1res[d];
   endfunction
   function automatic logic rerr(input int d, input int r);
      return (r == 0) ? s0e[d] : s1e[d];
   endfunction
   function automatic logic cur_valid(input int d, input int r);
      return (r == 0) ? r0v[d] : r1v[d];
   endfunction
   function automatic logic rsp_rdy(input int d, input int r);
      return (r == 0) ? s0r[d] : s1r[d];
   endfunction

   task automatic drive_req(input int d, input int r, input logic v, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin r0v[d] = v; r0op[d] = op; r0a[d] = a; r0b[d] = b; end
      else        begin r1v[d] = v; r1op[d] = op; r1a[d] = a; r1b[d] = b; end
   endtask

   task automatic set_rr(input int d, input int r, input logic v);
      if (r == 0) s0r[d] = v; else s1r[d] = v;
   endtask

   // Reference: result and error flag straight from the op-code table.
   function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0:    return {1'b0, 32'(a + b)};
         4'd2:    return {1'b0, 32'(a - b)};
         4'd4:    return {1'b0, a & b};
         4'd5:    return {1'b0, a | b};
         4'd6:    return {1'b0, a ^ b};
         4'd7:    return {1'b0, ~(a | b)};
         4'd10:   return {1'b0, (sa - sb < 0) ? 32'd1 : 32'd0};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   task automatic pulse_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input int d, input string name);
      check({name, " req0_ready"}, r0rdy[d], 0);
      check({name, " req1_ready"}, r1rdy[d], 0);
      check({name, " rsp0_valid"}, s0v[d], 0);
      check({name, " rsp1_valid"}, s1v[d], 0);
      check({name, " rsp0_res"}, s0res[d], 0);
      check({name, " rsp1_res"}, s1res[d], 0);
      check({name, " rsp0_err"}, s0e[d], 0);
      check({name, " rsp1_err"}, s1e[d], 0);
      check({name, " busy"}, bsy[d], 0);
   endtask

   // One complete transaction with rsp_ready high; checks accept, N+2 latency and result.
   task automatic run_op(input int d, input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err,
                         input string name);
      int waited;
      waited = 0;
      @(posedge clk); #1;
      drive_req(d, r, 1'b1, op, a, b);
      set_rr(d, r, 1'b1);
      @(negedge clk);
      while (!rdy(d, r) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({name, " accept"}, rdy(d, r), 1);
      check({name, " accept wait"}, waited, 0);
      @(posedge clk); #1;
      drive_req(d, r, 1'b0, 4'd0, 32'd0, 32'd0);
      @(negedge clk);
      check({name, " no rsp at N+1"}, rv(d, r), 0);
      check({name, " busy at N+1"}, bsy[d], 1);
      @(negedge clk);
      check({name, " rsp valid at N+2"}, rv(d, r), 1);
      check({name, " res"}, rres(d, r), exp_res);
      check({name, " err"}, rerr(d, r), exp_err);
      check({name, " other rsp idle"}, rv(d, 1 - r), 0);
   endtask

   task automatic rr_test();
      int exp_g;
      int last;
      int ngr;
      exp_g = 0; last = -1; ngr = 0;
      pulse_reset();
      drive_req(0, 0, 1'b1, 4'd0, 32'd1, 32'd1);
      drive_req(0, 1, 1'b1, 4'd6, 32'hF0, 32'hFF);
      set_rr(0, 0, 1'b1); set_rr(0, 1, 1'b1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (r0rdy[0] || r1rdy[0]) begin
            check("rr grant id", {31'd0, r1rdy[0]}, exp_g);
            check("rr single grant", {31'd0, r0rdy[0] & r1rdy[0]}, 0);
            if (last >= 0) check("rr spacing", cyc - last, 3);
            exp_g = 1 - exp_g;
            last = cyc;
            ngr++;
         end
         if (s0v[0]) check("rr res0", s0res[0], 32'd2);
         if (s1v[0]) check("rr res1", s1res[0], 32'h0F);
      end
      check("rr grant count", ngr, 7);
      @(posedge clk); #1;
      drive_req(0, 0, 1'b0, 4'd0, 0, 0);
      drive_req(0, 1, 1'b0, 4'd0, 0, 0);
      repeat (4) @(posedge clk);
   endtask

   task automatic fp_test();
      int n0;
      int waited;
      n0 = 0; waited = 0;
      pulse_reset();
      drive_req(1, 0, 1'b1, 4'd0, 32'd1, 32'd1);
      drive_req(1, 1, 1'b1, 4'd6, 32'hF0, 32'hFF);
      set_rr(1, 0, 1'b1); set_rr(1, 1, 1'b1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("fp req1 blocked", r1rdy[1], 0);
         if (r0rdy[1]) n0++;
      end
      check("fp req0 grants", n0, 4);
      @(posedge clk); #1;
      drive_req(1, 0, 1'b0, 4'd0, 0, 0);
      @(negedge clk);
      while (!r1rdy[1] && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("fp req1 granted", r1rdy[1], 1);
      @(posedge clk); #1;
      drive_req(1, 1, 1'b0, 4'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("fp rsp1 valid", s1v[1], 1);
      check("fp rsp1 res", s1res[1], 32'h0F);
      repeat (2) @(posedge clk);
   endtask

   task automatic bp_test();
      pulse_reset();
      @(posedge clk); #1;
      drive_req(0, 0, 1'b1, 4'd4, 32'hFF00, 32'h0FF0);
      set_rr(0, 0, 1'b0); set_rr(0, 1, 1'b1);
      @(negedge clk);
      check("bp accept", r0rdy[0], 1);
      @(posedge clk); #1;
      drive_req(0, 0, 1'b0, 4'd0, 0, 0);
      drive_req(0, 1, 1'b1, 4'd0, 32'd1, 32'd2);
      @(negedge clk);
      check("bp exec req1_ready", r1rdy[0], 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp rsp0 valid", s0v[0], 1);
         check("bp rsp0 res", s0res[0], 32'h0F00);
         check("bp req1_ready", r1rdy[0], 0);
      end
      s0r[0] = 1'b1;
      @(negedge clk);
      check("bp req1 first idle", r1rdy[0], 1);
      check("bp rsp0 dropped", s0v[0], 0);
      @(posedge clk); #1;
      drive_req(0, 1, 1'b0, 4'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("bp rsp1 valid", s1v[0], 1);
      check("bp rsp1 res", s1res[0], 32'd3);
      repeat (2) @(posedge clk);
   endtask

   task automatic reset_midop_test();
      logic seen;
      seen = 1'b0;
      pulse_reset();
      // Complete one req0 op so the round-robin pointer moves to requester 1.
      run_op(0, 0, 4'd0, 32'd2, 32'd2, 32'd4, 1'b0, "pre-reset");
      @(posedge clk); #1;
      drive_req(0, 0, 1'b1, 4'd0, 32'd10, 32'd20);
      set_rr(0, 0, 1'b0);
      @(negedge clk);
      check("midop accept", r0rdy[0], 1);
      @(posedge clk); #1;
      drive_req(0, 0, 1'b0, 4'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("midop in resp", s0v[0], 1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs(0, "midop");
      reset = 1'b0;
      s0r[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (s0v[0]) seen = 1'b1;
      end
      check("midop no response", seen, 0);
      @(posedge clk); #1;
      drive_req(0, 0, 1'b1, 4'd0, 32'd1, 32'd1);
      drive_req(0, 1, 1'b1, 4'd0, 32'd1, 32'd1);
      @(negedge clk);
      check("midop ptr req0", r0rdy[0], 1);
      check("midop ptr not req1", r1rdy[0], 0);
      @(posedge clk); #1;
      drive_req(0, 0, 1'b0, 4'd0, 0, 0);
      drive_req(0, 1, 1'b0, 4'd0, 0, 0);
      repeat (3) @(posedge clk);
      run_op(0, 1, 4'd5, 32'h30, 32'h03, 32'h33, 1'b0, "post-reset req1");
   endtask

   task automatic rand_test(input int ncyc);
      logic [32:0] q0 [$];
      logic [32:0] q1 [$];
      logic        drop [2];
      logic [32:0] e;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ops [7];
      int          nresp;
      logic        draining;
      ops = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
      nresp = 0;
      drop[0] = 1'b0; drop[1] = 1'b0;
      pulse_reset();
      for (int k = 0; k < ncyc; k++) begin
         draining = (k >= ncyc - 12);
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) begin
            if (drop[r]) begin
               drive_req(0, r, 1'b0, 4'd0, 0, 0);
               drop[r] = 1'b0;
            end
            if (!draining && !cur_valid(0, r) && $urandom_range(0, 2) == 0) begin
               op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
               case ($urandom_range(0, 3))
                  0:       begin a = 32'hFFFF_FFFF; b = $urandom_range(0, 3); end
                  1:       begin a = 32'h8000_0000; b = $urandom; end
                  default: begin a = $urandom; b = $urandom; end
               endcase
               drive_req(0, r, 1'b1, op, a, b);
            end
            set_rr(0, r, draining ? 1'b1 : ($urandom_range(0, 3) != 0));
         end
         @(negedge clk);
         check("rand one rsp", {31'd0, s0v[0] & s1v[0]}, 0);
         for (int r = 0; r < 2; r++) begin
            if (rdy(0, r)) begin
               e = (r == 0) ? model(r0op[0], r0a[0], r0b[0]) : model(r1op[0], r1a[0], r1b[0]);
               if (r == 0) q0.push_back(e); else q1.push_back(e);
               drop[r] = 1'b1;
            end
            if (rv(0, r) && rsp_rdy(0, r)) begin
               if ((r == 0 ? q0.size() : q1.size()) == 0) begin
                  check("rand unexpected rsp", r, 32'hFFFF_FFFF);
               end else begin
                  e = (r == 0) ? q0.pop_front() : q1.pop_front();
                  check("rand res", rres(0, r), e[31:0]);
                  check("rand err", rerr(0, r), e[32]);
                  nresp++;
               end
            end
         end
      end
      check("rand q0 drained", q0.size(), 0);
      check("rand q1 drained", q1.size(), 0);
      check("rand enough traffic", nresp > 50, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [$];
      for (int d = 0; d < 2; d++) begin
         drive_req(d, 0, 1'b0, 4'd0, 0, 0);
         drive_req(d, 1, 1'b0, 4'd0, 0, 0);
         set_rr(d, 0, 1'b0);
         set_rr(d, 1, 1'b0);
      end
      vecs.push_back('{r: 0, op: 4'd0,  a: 32'd5,        b: 32'd3,        res: 32'd8,        err: 1'b0, name: "add"});
      vecs.push_back('{r: 1, op: 4'd2,  a: 32'd0,        b: 32'd1,        res: 32'hFFFFFFFF, err: 1'b0, name: "sub wrap"});
      vecs.push_back('{r: 0, op: 4'd4,  a: 32'hFF00,     b: 32'h0FF0,     res: 32'h0F00,     err: 1'b0, name: "and"});
      vecs.push_back('{r: 1, op: 4'd5,  a: 32'd7,        b: 32'd8,        res: 32'd15,       err: 1'b0, name: "or"});
      vecs.push_back('{r: 0, op: 4'd6,  a: 32'hF0,       b: 32'hFF,       res: 32'h0F,       err: 1'b0, name: "xor"});
      vecs.push_back('{r: 1, op: 4'd7,  a: 32'd0,        b: 32'd0,        res: 32'hFFFFFFFF, err: 1'b0, name: "nor"});
      vecs.push_back('{r: 0, op: 4'd10, a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd1,        err: 1'b0, name: "slt neg"});
      vecs.push_back('{r: 1, op: 4'd10, a: 32'd1,        b: 32'hFFFFFFFF, res: 32'd0,        err: 1'b0, name: "slt pos"});
      vecs.push_back('{r: 1, op: 4'd10, a: 32'h80000000, b: 32'h7FFFFFFF, res: 32'd1,        err: 1'b0, name: "slt min"});
      vecs.push_back('{r: 0, op: 4'd0,  a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd0,        err: 1'b0, name: "add wrap"});
      vecs.push_back('{r: 0, op: 4'd15, a: 32'd7,        b: 32'd8,        res: 32'd0,        err: 1'b1, name: "unsup 1111"});
      vecs.push_back('{r: 0, op: 4'd5,  a: 32'd7,        b: 32'd8,        res: 32'd15,       err: 1'b0, name: "after unsup"});
      vecs.push_back('{r: 1, op: 4'd1,  a: 32'd3,        b: 32'd3,        res: 32'd0,        err: 1'b1, name: "unsup 0001"});

      pulse_reset();
      @(negedge clk);
      check_reset_outputs(0, "reset rr");
      check_reset_outputs(1, "reset fp");

      for (int i = 0; i < vecs.size(); i++) begin
         run_op(0, vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, vecs[i].name);
      end
      repeat (2) @(posedge clk);

      rr_test();
      fp_test();
      bp_test();
      reset_midop_test();
      rand_test(1500);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
